// File: rtl/sseg_scan_mux_pkg.sv
// Shared constants and types for the 4-digit display scan path.
// Segment patterns are active-low: [7:1]=gfedcba, [0]=dp.
package sseg_scan_mux_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'b0111_1111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    // One-hot-low anode enable for the selected digit.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-MOD counter with a single-cycle wrap pulse.
// Counts on inc; clr forces zero; wrap marks the MOD-1 -> 0 step.
module tick_prescaler #(
    parameter int MOD = 8,
    localparam int W = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = inc && (cnt == LAST);

    // Count register: reset/clear to zero, roll over at LAST.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexes four segment patterns onto a common-anode display
// with per-slot blanking, frame-boundary snapshots and per-digit blink.
module sseg_scan_mux
    import sseg_scan_mux_pkg::*;
#(
    parameter int DIGIT_TICKS  = 100000,
    parameter int BLANK_TICKS  = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] sSegAN0,
    input  logic [7:0] sSegAN1,
    input  logic [7:0] sSegAN2,
    input  logic [7:0] sSegAN3,
    input  logic [3:0] blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick_wrap;
    logic [1:0]    digit_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_wrap;
    logic          blink_phase;
    logic          snap;

    logic [7:0]    shadow [NUM_DIGITS];
    logic [3:0]    shadow_blink;

    phase_t        state;
    phase_t        state_nx;

    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    // Snapshot only at the very first cycle of a frame while scanning.
    assign snap = en && (digit_idx == 2'd0) && (tick_cnt == '0);

    tick_prescaler #(
        .MOD (DIGIT_TICKS)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (~en),
        .inc  (en),
        .cnt  (tick_cnt),
        .wrap (tick_wrap)
    );

    tick_prescaler #(
        .MOD (BLINK_FRAMES)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .inc  (snap),
        .cnt  (blink_cnt),
        .wrap (blink_wrap)
    );

    // Digit slot index; held at 0 while scanning is disabled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            digit_idx <= 2'd0;
        end else if (tick_wrap) begin
            digit_idx <= digit_idx + 2'd1;
        end
    end

    // Blink phase toggles every BLINK_FRAMES snapshots.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            blink_phase <= ~blink_phase;
        end
    end

    // Shadow copies of the inputs, refreshed only at frame boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= SEG_BLANK;
            end
            shadow_blink <= 4'b0000;
        end else if (snap) begin
            shadow[0]    <= sSegAN0;
            shadow[1]    <= sSegAN1;
            shadow[2]    <= sSegAN2;
            shadow[3]    <= sSegAN3;
            shadow_blink <= blink_en;
        end
    end

    // Slot phase register; tracks whether tick_cnt is past the blank window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PH_BLANK;
        end else begin
            state <= state_nx;
        end
    end

    // Phase follows tick_cnt: every slot restarts in BLANK.
    always_comb begin
        state_nx = state;
        if (!en || tick_wrap) begin
            state_nx = PH_BLANK;
        end else if (tick_cnt == BLANK_LAST) begin
            state_nx = PH_DRIVE;
        end
    end

    // Output decode for the current slot, blank unless driving a visible digit.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK[7:1];
        dp_d  = SEG_BLANK[0];
        unique case (state)
            PH_BLANK: begin
                an_d = AN_OFF;
            end
            PH_DRIVE: begin
                if (en && !(blink_phase && shadow_blink[digit_idx])) begin
                    an_d  = an_select(digit_idx);
                    seg_d = shadow[digit_idx][7:1];
                    dp_d  = shadow[digit_idx][0];
                end
            end
            default: begin
                an_d = AN_OFF;
            end
        endcase
    end

    // Registered pins: one cycle behind the internal state.
    always_ff @(posedge clk) begin
        if (rst) begin
            an          <= AN_OFF;
            seg         <= SEG_BLANK[7:1];
            dp          <= SEG_BLANK[0];
            frame_start <= 1'b0;
        end else begin
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= snap;
        end
    end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Bench for sseg_scan_mux with a small frame-position reference model.
// Uses DIGIT_TICKS=8, BLANK_TICKS=2, BLINK_FRAMES=2.
module tb_sseg_scan_mux;
    import sseg_scan_mux_pkg::*;

    localparam int DT = 8;
    localparam int BT = 2;
    localparam int BF = 2;
    localparam int FRAME = 4 * DT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] a0 = 8'hFF;
    logic [7:0] a1 = 8'hFF;
    logic [7:0] a2 = 8'hFF;
    logic [7:0] a3 = 8'hFF;
    logic [3:0] blink_en = 4'b0000;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int tests = 0;
    int fails = 0;

    // reference model state
    int         m_p = 0;
    logic [7:0] m_sh [4];
    logic [3:0] m_bl = 4'b0000;
    int         m_snaps = 0;
    logic       m_phase = 1'b0;

    // expected pins after the most recent edge
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fs;
    int         exp_p;

    sseg_scan_mux #(
        .DIGIT_TICKS  (DT),
        .BLANK_TICKS  (BT),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sSegAN0     (a0),
        .sSegAN1     (a1),
        .sSegAN2     (a2),
        .sSegAN3     (a3),
        .blink_en    (blink_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Advance one clock; model predicts pins from pre-edge state.
    task automatic tick();
        logic [1:0] s;
        int off;
        @(posedge clk);
        s = 2'(m_p / DT);
        off = m_p % DT;
        exp_fs = 1'b0;
        exp_an = 4'hF;
        exp_seg = 7'h7F;
        exp_dp = 1'b1;
        exp_p = -1;
        if (!rst && en) begin
            exp_p = m_p;
            exp_fs = (m_p == 0);
            if (off >= BT && !(m_phase && m_bl[s])) begin
                exp_an = ~(4'b0001 << s);
                exp_seg = m_sh[s][7:1];
                exp_dp = m_sh[s][0];
            end
        end
        if (rst) begin
            m_p = 0;
            for (int i = 0; i < 4; i++) m_sh[i] = 8'hFF;
            m_bl = 4'b0000;
            m_snaps = 0;
            m_phase = 1'b0;
        end else if (!en) begin
            m_p = 0;
        end else begin
            if (m_p == 0) begin
                m_sh[0] = a0;
                m_sh[1] = a1;
                m_sh[2] = a2;
                m_sh[3] = a3;
                m_bl = blink_en;
                m_snaps++;
                m_phase = ((m_snaps / BF) % 2) == 1;
            end
            m_p = (m_p + 1) % FRAME;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({an, seg, dp, frame_start} !== {AN_OFF, 7'h7F, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL reset an=%b seg=%b dp=%b fs=%b want 1111/1111111/1/0",
                         an, seg, dp, frame_start);
            end
        end
        rst = 1'b0;
        tick();
        tests++;
        if (frame_start !== 1'b1 || an !== 4'hF) begin
            fails++;
            $display("FAIL reset_release fs=%b an=%b want fs=1 an=1111", frame_start, an);
        end
        tick();
        tests++;
        if (frame_start !== 1'b0) begin
            fails++;
            $display("FAIL reset_fs_width fs=%b want 0", frame_start);
        end
    endtask

    task automatic test_static();
        int last_fs;
        int gap;
        a0 = 8'b1000_0001;
        a1 = 8'b1111_0011;
        a2 = 8'b0100_1000;
        a3 = SEG_MINUS;
        blink_en = 4'b0000;
        last_fs = -1;
        gap = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            tests++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                fails++;
                $display("FAIL static p=%0d an=%b seg=%b dp=%b fs=%b want %b %b %b %b",
                         exp_p, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) gap = c - last_fs;
                last_fs = c;
            end
            if (c >= FRAME + 1 && exp_p == 5) begin
                tests++;
                if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
                    fails++;
                    $display("FAIL slot0 an=%b seg=%b dp=%b want 1110 1000000 1", an, seg, dp);
                end
            end
            if (c >= FRAME + 1 && exp_p == 21) begin
                tests++;
                if ({an, seg, dp} !== {4'b1011, 7'b0100100, 1'b0}) begin
                    fails++;
                    $display("FAIL slot2 an=%b seg=%b dp=%b want 1011 0100100 0", an, seg, dp);
                end
            end
            if (c >= FRAME + 1 && exp_p == 29) begin
                tests++;
                if ({an, seg} !== {4'b0111, 7'b0111111}) begin
                    fails++;
                    $display("FAIL slot3 an=%b seg=%b want 0111 0111111", an, seg);
                end
            end
            if (c >= FRAME + 1 && exp_p == 9) begin
                tests++;
                if (an !== 4'hF) begin
                    fails++;
                    $display("FAIL slot_blank an=%b want 1111", an);
                end
            end
        end
        tests++;
        if (gap != FRAME) begin
            fails++;
            $display("FAIL fs_period got=%0d want=%0d", gap, FRAME);
        end
    endtask

    task automatic test_tearing();
        int stage;
        stage = 0;
        for (int c = 0; c < 4 * FRAME && stage < 3; c++) begin
            tick();
            tests++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                fails++;
                $display("FAIL tearing p=%0d an=%b seg=%b fs=%b want %b %b %b",
                         exp_p, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            if (stage == 0 && exp_p == 12) begin
                a3 = 8'h81;
                stage = 1;
            end else if (stage == 1 && exp_p == 29) begin
                tests++;
                if (seg !== 7'b0111111) begin
                    fails++;
                    $display("FAIL tear_old seg=%b want 0111111", seg);
                end
                stage = 2;
            end else if (stage == 2 && exp_p == 29) begin
                tests++;
                if (seg !== 7'b1000000 || an !== 4'b0111) begin
                    fails++;
                    $display("FAIL tear_new seg=%b an=%b want 1000000 0111", seg, an);
                end
                stage = 3;
            end
        end
        tests++;
        if (stage != 3) begin
            fails++;
            $display("FAIL tear_timeout stage=%0d want 3", stage);
        end
    endtask

    task automatic test_blink();
        int on0;
        int off0;
        blink_en = 4'b0001;
        on0 = 0;
        off0 = 0;
        for (int c = 0; c < 6 * FRAME; c++) begin
            tick();
            tests++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                fails++;
                $display("FAIL blink p=%0d an=%b seg=%b fs=%b want %b %b %b",
                         exp_p, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            if (exp_p >= DT && (exp_p % DT) >= BT) begin
                tests++;
                if (an === 4'hF) begin
                    fails++;
                    $display("FAIL blink_other p=%0d an=%b want digit driven", exp_p, an);
                end
            end
            if (c >= FRAME && exp_p == 4) begin
                if (an === 4'b1110) on0++;
                else off0++;
            end
        end
        tests++;
        if (on0 < 2 || off0 < 2) begin
            fails++;
            $display("FAIL blink_phases on=%0d off=%0d want both >=2", on0, off0);
        end
        blink_en = 4'b0000;
    endtask

    task automatic test_enable();
        int found;
        found = 0;
        for (int c = 0; c < 2 * FRAME && found == 0; c++) begin
            tick();
            if (exp_p == 20) found = 1;
        end
        tests++;
        if (found == 0) begin
            fails++;
            $display("FAIL en_timeout found=0 want 1");
        end
        en = 1'b0;
        tick();
        tests++;
        if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL en_off an=%b seg=%b dp=%b fs=%b want blank", an, seg, dp, frame_start);
        end
        for (int c = 0; c < 3; c++) tick();
        en = 1'b1;
        tick();
        tests++;
        if (frame_start !== 1'b1 || an !== 4'hF) begin
            fails++;
            $display("FAIL en_fs fs=%b an=%b want 1 1111", frame_start, an);
        end
        tick();
        tests++;
        if (an !== 4'hF || frame_start !== 1'b0) begin
            fails++;
            $display("FAIL en_blank an=%b fs=%b want 1111 0", an, frame_start);
        end
        tick();
        tests++;
        if (an !== 4'b1110) begin
            fails++;
            $display("FAIL en_digit0 an=%b want 1110", an);
        end
    endtask

    task automatic test_mid_reset();
        int found;
        found = 0;
        for (int c = 0; c < 2 * FRAME && found == 0; c++) begin
            tick();
            if (exp_p == 28) found = 1;
        end
        tests++;
        if (found == 0 || an !== 4'b0111) begin
            fails++;
            $display("FAIL mid_rst_setup found=%0d an=%b want 1 0111", found, an);
        end
        rst = 1'b1;
        tick();
        tests++;
        if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL mid_rst an=%b seg=%b dp=%b fs=%b want blank", an, seg, dp, frame_start);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (frame_start !== 1'b1) begin
            fails++;
            $display("FAIL mid_rst_fs fs=%b want 1", frame_start);
        end
        for (int c = 0; c < FRAME + 4; c++) begin
            tick();
            tests++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                fails++;
                $display("FAIL mid_rst_run p=%0d an=%b seg=%b fs=%b want %b %b %b",
                         exp_p, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 9) == 0) a0 = 8'($urandom);
            if ($urandom_range(0, 9) == 0) a1 = 8'($urandom);
            if ($urandom_range(0, 9) == 0) a2 = 8'($urandom);
            if ($urandom_range(0, 9) == 0) a3 = 8'($urandom);
            if ($urandom_range(0, 40) == 0) blink_en = 4'($urandom);
            if ($urandom_range(0, 60) == 0) en = ~en;
            rst = ($urandom_range(0, 250) == 0);
            tick();
            tests++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                fails++;
                $display("FAIL random p=%0d an=%b seg=%b dp=%b fs=%b want %b %b %b %b",
                         exp_p, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            tests++;
            if ($countones(~an) > 1) begin
                fails++;
                $display("FAIL one_anode an=%b want at most one low", an);
            end
        end
        rst = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_sh[i] = 8'hFF;
        test_reset();
        test_static();
        test_tearing();
        test_blink();
        test_enable();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
